// File: rtl/icache_ctrl_if.sv
// CPU fetch and instruction-memory signals of the instruction cache.
// The cache takes the slave side. The master side is the CPU fetch stage
// plus the memory.
interface icache_ctrl_if;
    logic [31:0]  address;
    logic         read;
    logic         flush;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport master (
        output address, read, flush, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

    modport slave (
        input  address, read, flush, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with 4-word lines.
// A hit returns the instruction in the same cycle with no wait.
// A miss stalls the CPU and fills the line from a multi-cycle memory.
// A flush invalidates every line. If the flush arrives during a fill, it is
// deferred until the fill has finished.
module icache_ctrl #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input logic          CLK,
    input logic          RESET,
    icache_ctrl_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t state, state_next;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_array  [LINES];
    logic [127:0]        data_array [LINES];
    logic [127:0]        fill_q;
    logic [31:0]         instr_q;
    logic                flush_pending;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [127:0]          line;
    logic [31:0]           word;
    logic                  hit;

    // Control decoded from state
    logic        serve;
    logic        fill_en;
    logic        clear_valid;
    logic        busywait;
    logic        mem_read;
    logic [27:0] mem_address;

    // Bits [1:0] of the address select a byte within a word, so they are not used.
    logic unused_addr;
    assign unused_addr = ^bus.address[1:0];

    assign offset = bus.address[3:2];
    assign index  = bus.address[INDEX_BITS+3:4];
    assign tag    = bus.address[31:INDEX_BITS+4];
    assign line   = data_array[index];
    assign hit    = bus.read & valid[index] & (tag_array[index] == tag);

    // Select the requested word from the indexed line.
    always_comb begin
        word = line[31:0];
        case (offset)
            2'd0: word = line[31:0];
            2'd1: word = line[63:32];
            2'd2: word = line[95:64];
            2'd3: word = line[127:96];
            default: word = line[31:0];
        endcase
    end

    // Next-state and output decode. A pending flush takes one whole IDLE
    // cycle with busywait high, so that the next lookup sees the cleared valids.
    always_comb begin
        state_next  = state;
        busywait    = 1'b0;
        mem_read    = 1'b0;
        mem_address = 28'h0;
        serve       = 1'b0;
        fill_en     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pending) begin
                    busywait    = 1'b1;
                    clear_valid = 1'b1;
                end else begin
                    clear_valid = bus.flush;
                    if (hit) begin
                        serve = 1'b1;
                    end else if (bus.read) begin
                        busywait   = 1'b1;
                        state_next = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = bus.address[31:4];
                busywait    = 1'b1;
                if (!bus.mem_busywait) begin
                    fill_en    = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busywait   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busywait    = busywait;
    assign bus.mem_read    = mem_read;
    assign bus.mem_address = mem_address;
    assign bus.instruction = serve ? word : instr_q;

    // State register. Reset abandons any fill in flight.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // A flush seen during a fill is remembered until the cache is back in IDLE.
    always_ff @(posedge CLK) begin
        if (RESET)                                flush_pending <= 1'b0;
        else if (state != IDLE && bus.flush)      flush_pending <= 1'b1;
        else if (state == IDLE && flush_pending)  flush_pending <= 1'b0;
    end

    // Valid bits: cleared by reset or flush, set when a line is installed.
    always_ff @(posedge CLK) begin
        if (RESET)                valid        <= '0;
        else if (clear_valid)     valid        <= '0;
        else if (state == UPDATE) valid[index] <= 1'b1;
    end

    // Capture the returned block in the cycle the memory drops busywait.
    always_ff @(posedge CLK) begin
        if (fill_en) fill_q <= bus.mem_readdata;
    end

    // Install the filled line. Tag and data have no reset because valid guards them.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            tag_array[index]  <= tag;
            data_array[index] <= fill_q;
        end
    end

    // Hold the last served instruction while read is low or the CPU is stalled.
    always_ff @(posedge CLK) begin
        if (RESET)      instr_q <= 32'h0;
        else if (serve) instr_q <= word;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl. It uses a 4-cycle instruction-memory model.
// Most cases are table-driven fetches. Flush, read-low hold and reset in the
// middle of a fill are covered by hand-written sequences.
module tb_icache_ctrl;
    localparam int LAT = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   mcnt   = 0;

    icache_ctrl_if bif ();

    icache_ctrl #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif)
    );

    always #5 CLK = ~CLK;

    // Each word's contents are a scrambled form of its word address.
    function automatic logic [31:0] word_val(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) + 32'h1357_9BDF;
    endfunction

    // Memory model: data becomes valid in the LAT-th cycle of mem_read.
    always @(posedge CLK) begin
        if (!bif.mem_read || mcnt == LAT - 1) mcnt <= 0;
        else                                  mcnt <= mcnt + 1;
    end
    assign bif.mem_busywait = bif.mem_read ? (mcnt != LAT - 1) : 1'b0;
    assign bif.mem_readdata = {word_val({bif.mem_address, 4'hC}), word_val({bif.mem_address, 4'h8}),
                               word_val({bif.mem_address, 4'h4}), word_val({bif.mem_address, 4'h0})};

    typedef struct {
        logic [31:0] addr;
        int          flush_cyc;  // cycle of the fetch in which flush pulses; -1 means none
        int          exp_busy;   // number of cycles busywait is high before the hit
        logic        exp_mr;     // mem_read expected at some point
        logic [27:0] exp_maddr;
    } fetch_vec_t;

    fetch_vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fetch(input int n);
        fetch_vec_t v = tbl[n];
        int          cyc = 0;
        int          busy = 0;
        logic        saw_mr = 1'b0;
        logic [27:0] maddr = 28'h0;
        bit          done = 0;
        @(posedge CLK); #1;
        bif.address = v.addr;
        bif.read    = 1'b1;
        bif.flush   = (v.flush_cyc == 0);
        while (!done && cyc < 60) begin
            @(negedge CLK);
            if (bif.busywait) begin
                busy++;
                if (bif.mem_read) begin
                    saw_mr = 1'b1;
                    maddr  = bif.mem_address;
                end
                @(posedge CLK); #1;
                cyc++;
                bif.flush = (cyc == v.flush_cyc);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL fetch[%0d] timeout: busywait still high after %0d cycles, required low", n, cyc);
        end else begin
            chk($sformatf("fetch[%0d] busy_cycles", n), busy, v.exp_busy);
            chk($sformatf("fetch[%0d] mem_read_seen", n), {31'b0, saw_mr}, {31'b0, v.exp_mr});
            if (v.exp_mr) chk($sformatf("fetch[%0d] mem_address", n), {4'b0, maddr}, {4'b0, v.exp_maddr});
            chk($sformatf("fetch[%0d] instruction", n), bif.instruction, word_val(v.addr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          flush busy mr   maddr
        tbl[0]  = '{32'h0000_0000, -1,  6,  1'b1, 28'h0};  // cold miss
        tbl[1]  = '{32'h0000_0000, -1,  0,  1'b0, 28'h0};  // sequential hits
        tbl[2]  = '{32'h0000_0004, -1,  0,  1'b0, 28'h0};
        tbl[3]  = '{32'h0000_0008, -1,  0,  1'b0, 28'h0};
        tbl[4]  = '{32'h0000_000C, -1,  0,  1'b0, 28'h0};
        tbl[5]  = '{32'h0000_0010, -1,  6,  1'b1, 28'h1};  // conflict on index 1
        tbl[6]  = '{32'h0000_0090, -1,  6,  1'b1, 28'h9};
        tbl[7]  = '{32'h0000_0010, -1,  6,  1'b1, 28'h1};
        tbl[8]  = '{32'h0000_0014, -1,  0,  1'b0, 28'h0};
        tbl[9]  = '{32'h0000_007C, -1,  6,  1'b1, 28'h7};  // last index, last word
        tbl[10] = '{32'h0000_0000, -1,  0,  1'b0, 28'h0};
        tbl[11] = '{32'h0000_0000,  0,  0,  1'b0, 28'h0};  // flush in IDLE, hit still served
        tbl[12] = '{32'h0000_0000, -1,  6,  1'b1, 28'h0};  // flushed line misses
        tbl[13] = '{32'h0000_0020,  2, 13,  1'b1, 28'h2};  // flush in MEM_READ: fill, +1, refill
        tbl[14] = '{32'h0000_0024, -1,  0,  1'b0, 28'h0};
        tbl[15] = '{32'h0000_0040,  5, 13,  1'b1, 28'h4};  // flush in UPDATE
        tbl[16] = '{32'h0000_0000, -1,  6,  1'b1, 28'h0};
        tbl[17] = '{32'h0000_0030, -1,  6,  1'b1, 28'h3};  // after reset mid-fill
        tbl[18] = '{32'h0000_0024, -1,  6,  1'b1, 28'h2};  // reset cleared valids

        RESET       = 1'b1;
        bif.address = 32'h0;
        bif.read    = 1'b0;
        bif.flush   = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset busywait",    {31'b0, bif.busywait}, 32'h0);
        chk("reset mem_read",    {31'b0, bif.mem_read}, 32'h0);
        chk("reset mem_address", {4'b0, bif.mem_address}, 32'h0);
        chk("reset instruction", bif.instruction, 32'h0);

        for (int i = 0; i <= 16; i++) fetch(i);

        // With read low, the last instruction is held and no stall is raised.
        @(posedge CLK); #1;
        bif.address = 32'h0000_0010;
        bif.read    = 1'b0;
        bif.flush   = 1'b0;
        @(negedge CLK);
        chk("idle hold instruction", bif.instruction, word_val(32'h0));
        chk("idle busywait",         {31'b0, bif.busywait}, 32'h0);
        chk("idle mem_read",         {31'b0, bif.mem_read}, 32'h0);

        // Reset in the 2nd cycle of MEM_READ.
        @(posedge CLK); #1;
        bif.address = 32'h0000_0030;
        bif.read    = 1'b1;
        @(posedge CLK); #1;                 // 1st MEM_READ cycle
        @(posedge CLK); #1;                 // 2nd MEM_READ cycle
        RESET = 1'b1;
        @(negedge CLK);
        chk("pre-reset mem_read", {31'b0, bif.mem_read}, 32'h1);
        @(posedge CLK); #1;
        RESET    = 1'b0;
        bif.read = 1'b0;
        @(negedge CLK);
        chk("midfill reset mem_read",    {31'b0, bif.mem_read}, 32'h0);
        chk("midfill reset busywait",    {31'b0, bif.busywait}, 32'h0);
        chk("midfill reset mem_address", {4'b0, bif.mem_address}, 32'h0);
        chk("midfill reset instruction", bif.instruction, 32'h0);

        for (int i = 17; i <= 18; i++) fetch(i);

        @(posedge CLK); #1;
        bif.read = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
